dw_cntr_gray: RTL and testbench

- Parametrised synchronous Gray-code counter.
- Keeps a binary count register and produces registered binary and Gray-coded outputs, so consecutive Gray values differ in exactly one bit.
- Supports up/down counting, count enable, synchronous binary load, terminal-count flag and an optional output pipeline stage.
- Used as the pointer/sequence source for clock-domain-crossing FIFOs and Gray-coded address generators, in place of a free binary counter followed by a combinational converter.

---
 rtl/dw_cntr_gray.sv | 83 ++++++++
 tb/tb_dw_cntr_gray.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dw_cntr_gray.sv
// Synchronous up/down binary counter with registered binary and Gray outputs,
// synchronous load, terminal-count flag and an optional output register stage.
module dw_cntr_gray #(
  parameter int unsigned width   = 8,
  parameter int unsigned rst_val = 0,
  parameter int unsigned out_reg = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             load,
  input  logic [width-1:0] data,
  input  logic             up_dn,
  output logic [width-1:0] count_bin,
  output logic [width-1:0] count_gray,
  output logic             tercnt
);

  localparam logic [width-1:0] RstVal = width'(rst_val);
  localparam logic [width-1:0] One    = width'(1);

  function automatic logic [width-1:0] to_gray(input logic [width-1:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic logic is_term(input logic [width-1:0] x, input logic up);
    return up ? (x == '1) : (x == '0);
  endfunction

  logic [width-1:0] cnt_q, cnt_d;
  logic [width-1:0] gray_q, gray_d;
  logic             tc_now;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = data;
    end else if (cen) begin
      cnt_d = up_dn ? cnt_q + One : cnt_q - One;
    end
    // Gray is registered from the next count so the output never glitches
    gray_d = to_gray(cnt_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= RstVal;
      gray_q <= to_gray(RstVal);
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
    end
  end

  assign tc_now = is_term(cnt_q, up_dn);

  if (out_reg != 0) begin : g_out_reg
    logic [width-1:0] bin_o_q;
    logic [width-1:0] gray_o_q;
    logic             tc_o_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        bin_o_q  <= RstVal;
        gray_o_q <= to_gray(RstVal);
        tc_o_q   <= is_term(RstVal, up_dn);
      end else begin
        bin_o_q  <= cnt_q;
        gray_o_q <= gray_q;
        tc_o_q   <= tc_now;
      end
    end

    assign count_bin  = bin_o_q;
    assign count_gray = gray_o_q;
    assign tercnt     = tc_o_q;
  end else begin : g_no_out_reg
    assign count_bin  = cnt_q;
    assign count_gray = gray_q;
    assign tercnt     = tc_now;
  end

endmodule

// File: tb/tb_dw_cntr_gray.sv
// Scoreboard bench for dw_cntr_gray: three configurations driven in lockstep
// and checked against an integer-arithmetic reference model.
module tb_dw_cntr_gray;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, load, cen, up_dn;
  logic [3:0] data;

  logic [3:0] bin_a, gray_a, bin_b, gray_b;
  logic [0:0] bin_c, gray_c;
  logic       tc_a, tc_b, tc_c;

  dw_cntr_gray #(.width(4), .rst_val(0), .out_reg(0)) u_dut_a (
    .clk(clk), .rst(rst), .cen(cen), .load(load), .data(data), .up_dn(up_dn),
    .count_bin(bin_a), .count_gray(gray_a), .tercnt(tc_a)
  );

  dw_cntr_gray #(.width(4), .rst_val(5), .out_reg(1)) u_dut_b (
    .clk(clk), .rst(rst), .cen(cen), .load(load), .data(data), .up_dn(up_dn),
    .count_bin(bin_b), .count_gray(gray_b), .tercnt(tc_b)
  );

  dw_cntr_gray #(.width(1), .rst_val(0), .out_reg(0)) u_dut_c (
    .clk(clk), .rst(rst), .cen(cen), .load(load), .data(data[0:0]), .up_dn(up_dn),
    .count_bin(bin_c), .count_gray(gray_c), .tercnt(tc_c)
  );

  typedef struct packed {
    logic            step;
    logic [2:0]      tc;
    logic [2:0][3:0] bin;
    logic [2:0][3:0] gry;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_cnt[3];
  int   wid[3]  = '{4, 4, 1};
  int   rv[3]   = '{0, 5, 0};
  int   oreg[3] = '{0, 1, 0};

  function automatic int gray_of(input int x);
    return x ^ (x >> 1);
  endfunction

  function automatic logic term_of(input int x, input int mask, input logic up);
    return up ? (x == mask) : (x == 0);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and push the outputs expected after that edge
  task automatic step(input logic r, input logic l, input logic c, input logic u,
                      input logic [3:0] d);
    exp_t e;
    int   mask, old, nxt;
    @(negedge clk);
    rst = r; load = l; cen = c; up_dn = u; data = d;
    e = '0;
    e.step = !r && !l && c;
    for (int i = 0; i < 3; i++) begin
      mask = (1 << wid[i]) - 1;
      old  = m_cnt[i];
      if (r)      nxt = rv[i];
      else if (l) nxt = int'(d) & mask;
      else if (c) nxt = u ? (old + 1) & mask : (old + mask) & mask;
      else        nxt = old;
      if (oreg[i] == 0) begin
        e.bin[i] = 4'(nxt);
        e.gry[i] = 4'(gray_of(nxt));
        e.tc[i]  = term_of(nxt, mask, u);
      end else if (r) begin
        e.bin[i] = 4'(rv[i]);
        e.gry[i] = 4'(gray_of(rv[i]));
        e.tc[i]  = term_of(rv[i], mask, u);
      end else begin
        e.bin[i] = 4'(old);
        e.gry[i] = 4'(gray_of(old));
        e.tc[i]  = term_of(old, mask, u);
      end
      m_cnt[i] = nxt;
    end
    sb_q.push_back(e);
  endtask

  // Monitor: pops one expectation per clock and compares all three DUTs
  initial begin
    exp_t       e;
    logic [3:0] prev_gray;
    prev_gray = '0;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("bin_a",  32'(bin_a),  32'(e.bin[0]));
        check("gray_a", 32'(gray_a), 32'(e.gry[0]));
        check("tc_a",   32'(tc_a),   32'(e.tc[0]));
        check("bin_b",  32'(bin_b),  32'(e.bin[1]));
        check("gray_b", 32'(gray_b), 32'(e.gry[1]));
        check("tc_b",   32'(tc_b),   32'(e.tc[1]));
        check("bin_c",  32'(bin_c),  32'(e.bin[2]));
        check("gray_c", 32'(gray_c), 32'(e.gry[2]));
        check("tc_c",   32'(tc_c),   32'(e.tc[2]));
        if (e.step) check("gray_one_bit_a", 32'($countones(gray_a ^ prev_gray)), 32'd1);
        prev_gray = gray_a;
      end
    end
  end

  initial begin
    logic r, l, c, u;
    logic [3:0] d;
    rst = 1'b1; load = 1'b0; cen = 1'b0; up_dn = 1'b1; data = '0;
    m_cnt = '{0, 0, 0};

    step(1, 0, 0, 1, 4'd0);
    step(1, 0, 0, 1, 4'd0);
    repeat (16) step(0, 0, 1, 1, 4'd0);  // full up cycle with wrap
    step(0, 0, 0, 0, 4'd0);              // terminal at 0 going down
    repeat (5) step(0, 0, 1, 0, 4'd0);   // down with wrap to all-ones
    step(0, 1, 1, 1, 4'd9);              // load beats cen
    repeat (3) step(0, 0, 0, 1, 4'd0);
    step(0, 1, 0, 1, 4'd6);
    step(0, 0, 1, 1, 4'd0);
    step(1, 1, 1, 1, 4'd3);              // reset beats load and cen
    step(0, 0, 0, 1, 4'd0);
    step(0, 1, 0, 1, 4'd14);
    repeat (2) step(0, 0, 0, 1, 4'd0);
    step(0, 0, 1, 1, 4'd0);
    step(0, 0, 0, 0, 4'd0);
    step(0, 0, 0, 1, 4'd0);
    step(0, 0, 0, 0, 4'd0);
    step(0, 0, 0, 1, 4'd0);

    repeat (400) begin
      r = ($urandom_range(0, 31) == 0);
      l = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 3) != 0);
      u = 1'($urandom_range(0, 1));
      d = 4'($urandom_range(0, 15));
      step(r, l, c, u, d);
    end

    for (int k = 0; k < 4 && sb_q.size() != 0; k++) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
